// File: rtl/parity4_rx_v.sv
// Nibble parity-link receiver: deserialises start + 4 data + parity + stop frames
// from an asynchronous line and reports the nibble with parity and framing errors.
module parity4_rx_v #(
    parameter int CLKS_PER_BIT = 8,
    parameter bit ODD_PARITY   = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [3:0] o_data,
    output logic       o_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state, state_next;
    logic             rx_meta, rx_s, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       bit_idx;
    logic [3:0]       shift_reg;
    logic             par_err;
    logic             cnt_clr, shift_en, par_load, out_load;

    // Line idles high, so the synchroniser resets to 1 to avoid a fake start edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, forming a true shift chain.
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        par_load   = 1'b0;
        out_load   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (rx_prev && !rx_s) state_next = START;
            end
            START: begin
                if (cnt == HALF_CNT) begin
                    cnt_clr    = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_CNT) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 2'd3) state_next = PARITY;
                end
            end
            PARITY: begin
                if (cnt == FULL_CNT) begin
                    cnt_clr    = 1'b1;
                    par_load   = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_CNT) begin
                    cnt_clr    = 1'b1;
                    out_load   = 1'b1;
                    state_next = rx_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                cnt_clr = 1'b1;
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit timing and shift register; bit_idx restarts whenever the receiver is idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_err   <= 1'b0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + 1'b1;
            if (state == IDLE)  bit_idx <= '0;
            else if (shift_en)  bit_idx <= bit_idx + 1'b1;
            if (shift_en)       shift_reg <= {rx_s, shift_reg[3:1]};
            if (par_load)       par_err <= rx_s ^ (^shift_reg) ^ ODD_PARITY;
        end
    end

    // Result registers hold until the next completed frame; false starts leave them alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_valid <= out_load;
            if (out_load) begin
                o_data       <= shift_reg;
                o_parity_err <= par_err;
                o_frame_err  <= ~rx_s;
            end
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_parity4_rx_v.sv
// Self-checking bench: even- and odd-parity receivers share one line; a scoreboard
// queue per receiver is filled by the stimulus and drained by a monitor on o_valid.
module tb_parity4_rx_v;

    localparam int N = 8;

    typedef struct {
        logic [3:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] data_e, data_o;
    logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t q_e[$];
    exp_t q_o[$];
    exp_t got_e, got_o;
    int   busy_run = 0;
    int   last_busy_run = 0;

    parity4_rx_v #(.CLKS_PER_BIT(N), .ODD_PARITY(1'b0)) dut_e (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx),
        .o_data(data_e), .o_valid(valid_e), .o_parity_err(perr_e),
        .o_frame_err(ferr_e), .o_busy(busy_e)
    );

    parity4_rx_v #(.CLKS_PER_BIT(N), .ODD_PARITY(1'b1)) dut_o (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx),
        .o_data(data_o), .o_valid(valid_o), .o_parity_err(perr_o),
        .o_frame_err(ferr_o), .o_busy(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: a parity error means the data ones plus the parity bit do not
    // add up to the configured sense (even count for ODD_PARITY=0, odd for 1).
    task automatic expect_frame(input logic [3:0] d, input logic par, input logic stop);
        int ones;
        exp_t x;
        ones   = $countones(d) + int'(par);
        x.data = d;
        x.ferr = !stop;
        x.perr = (ones % 2) != 0;
        q_e.push_back(x);
        x.perr = (ones % 2) != 1;
        q_o.push_back(x);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (N) @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0] d, input logic par, input logic stop, input int stop_len);
        drive_bit(1'b0);
        for (int k = 0; k < 4; k++) drive_bit(d[k]);
        drive_bit(par);
        rx = stop;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_e"}, data_e, 0);
        check({tag, "_data_o"}, data_o, 0);
        check({tag, "_valid"}, {valid_e, valid_o}, 0);
        check({tag, "_perr"}, {perr_e, perr_o}, 0);
        check({tag, "_ferr"}, {ferr_e, ferr_o}, 0);
        check({tag, "_busy"}, {busy_e, busy_o}, 0);
    endtask

    // Monitor: every o_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid_e) begin
            if (q_e.size() == 0) check("even_spurious_valid", q_e.size(), 1);
            else begin
                got_e = q_e.pop_front();
                check("even_data", data_e, got_e.data);
                check("even_parity_err", perr_e, got_e.perr);
                check("even_frame_err", ferr_e, got_e.ferr);
            end
        end
        if (valid_o) begin
            if (q_o.size() == 0) check("odd_spurious_valid", q_o.size(), 1);
            else begin
                got_o = q_o.pop_front();
                check("odd_data", data_o, got_o.data);
                check("odd_parity_err", perr_o, got_o.perr);
                check("odd_frame_err", ferr_o, got_o.ferr);
            end
        end
    end

    always @(negedge clk) begin
        if (busy_e) busy_run <= busy_run + 1;
        else begin
            if (busy_run != 0) last_busy_run <= busy_run;
            busy_run <= 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] d;
        logic       par, stop, seen_busy;
        logic [3:0] held;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(4);

        // Good frame 1011 with correct even parity; busy spans start sample through stop sample.
        expect_frame(4'b1011, 1'b1, 1'b1);
        send_frame(4'b1011, 1'b1, 1'b1, N);
        idle(N);
        check("busy_length", last_busy_run, N / 2 + 6 * N);

        // Same nibble with parity 0: error for even sense, clean for odd sense.
        expect_frame(4'b1011, 1'b0, 1'b1);
        send_frame(4'b1011, 1'b0, 1'b1, N);
        idle(N);

        // Stuck-low stop bit: framing error reported, busy held until the line recovers.
        expect_frame(4'b0000, 1'b0, 1'b0);
        send_frame(4'b0000, 1'b0, 1'b0, 30);
        rx = 1'b0;
        check("break_busy_held", {busy_e, busy_o}, 2'b11);
        rx = 1'b1;
        idle(6);
        check("break_busy_released", {busy_e, busy_o}, 2'b00);

        // Short low glitch: a false start must not report a frame or touch o_data.
        held = data_e;
        seen_busy = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < N / 2 + 4; i++) begin
            if (i == 3) rx = 1'b1;
            @(negedge clk);
            if (busy_e) seen_busy = 1'b1;
        end
        check("glitch_busy_seen", seen_busy, 1'b1);
        check("glitch_busy_cleared", {busy_e, busy_o}, 2'b00);
        check("glitch_data_held", data_e, held);
        idle(N);

        // Back-to-back frames with a single stop bit each.
        expect_frame(4'b0110, 1'b0, 1'b1);
        expect_frame(4'b1000, 1'b1, 1'b1);
        send_frame(4'b0110, 1'b0, 1'b1, N);
        send_frame(4'b1000, 1'b1, 1'b1, N);
        idle(2 * N);

        // Reset in the middle of data bit 2 discards the partial frame.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx = 1'b1;
        repeat (N / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midframe_reset");
        idle(3);
        rst_n = 1'b1;
        idle(2 * N);
        expect_frame(4'b0101, 1'b0, 1'b1);
        send_frame(4'b0101, 1'b0, 1'b1, N);
        idle(N);

        // Randomised frames: random data, parity and occasional broken stop bit.
        for (int f = 0; f < 12; f++) begin
            d    = 4'($urandom_range(0, 15));
            par  = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            expect_frame(d, par, stop);
            send_frame(d, par, stop, N);
            idle($urandom_range(2, 10));
        end

        idle(3 * N);
        check("even_queue_drained", q_e.size(), 0);
        check("odd_queue_drained", q_o.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
